// File: rtl/or32_bus_pkg.sv
// or32_bus_pkg: shared state encoding and core write-mask constants for the or32 bus aligner.
package or32_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} state_e;
  localparam logic [3:0] WE_LOAD = 4'h0;
  localparam logic [3:0] WE_BYTE = 4'h1;
  localparam logic [3:0] WE_WORD = 4'hF;
endpackage

// File: rtl/or32_lane_steer.sv
// or32_lane_steer: byte enables and lane-shifted write data for one half of a core access.
module or32_lane_steer
  import or32_bus_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [3:0]  i_we,
  input  logic [31:0] i_dat,
  input  logic        i_second,
  output logic [3:0]  o_mem_we,
  output logic [31:0] o_mem_dat_w
);
  logic [63:0] wide;
  logic [7:0]  mask;
  // upper halves of wide/mask are exactly the spill-over into the next word
  always_comb begin
    wide        = {32'h0, i_dat} << {i_off, 3'b000};
    mask        = 8'h0F << i_off;
    o_mem_we    = i_we == WE_LOAD ? 4'h0 :
                  i_we == WE_BYTE ? 4'b0001 << i_off :
                  i_second        ? mask[7:4] : mask[3:0];
    o_mem_dat_w = i_we == WE_BYTE ? {4{i_dat[7:0]}} :
                  i_second        ? wide[63:32] : wide[31:0];
  end
endmodule

// File: rtl/or32_bus_align.sv
// or32_bus_align: splits core byte-addressed requests into one or two word-aligned memory accesses
// and returns a single acknowledge with little-endian reassembled read data.
module or32_bus_align
  import or32_bus_pkg::*;
#(
  parameter bit SPLIT_UNALIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_dat_w,
  input  logic [3:0]  i_we,
  input  logic        i_stb,
  output logic [31:0] o_dat_r,
  output logic        o_ack,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_dat_w,
  output logic [3:0]  o_mem_we,
  output logic        o_mem_stb,
  input  logic [31:0] i_mem_dat_r,
  input  logic        i_mem_ack
);
  state_e      state_q, state_d;
  logic [31:0] dat_q, dat_d, lo_q, lo_d, dat_r_q, dat_r_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_dat_w_q, mem_dat_w_d;
  logic [3:0]  we_q, we_d, mem_we_q, mem_we_d;
  logic [1:0]  off_q, off_d, in_off, st_off;
  logic        ack_q, ack_d, mem_stb_q, mem_stb_d;
  logic [3:0]  st_we, st_mem_we;
  logic [31:0] st_dat, st_mem_dat_w, joined;
  logic        st_second, need2;
  // without splitting, word data ignores the offset but a byte store still picks its lane
  assign in_off    = (SPLIT_UNALIGNED || i_we == WE_BYTE) ? i_addr[1:0] : 2'b00;
  assign st_second = state_q != IDLE;
  assign st_off    = st_second ? off_q : in_off;
  assign st_we     = st_second ? we_q : i_we;
  assign st_dat    = st_second ? dat_q : i_dat_w;
  assign need2     = SPLIT_UNALIGNED && off_q != 2'b00 && we_q != WE_BYTE;
  assign joined    = 32'({i_mem_dat_r, lo_q} >> {off_q, 3'b000});

  or32_lane_steer u_steer (
    .i_off       (st_off),
    .i_we        (st_we),
    .i_dat       (st_dat),
    .i_second    (st_second),
    .o_mem_we    (st_mem_we),
    .o_mem_dat_w (st_mem_dat_w)
  );

  always_comb begin
    state_d     = state_q;
    dat_d       = dat_q;
    lo_d        = lo_q;
    we_d        = we_q;
    off_d       = off_q;
    dat_r_d     = dat_r_q;
    mem_addr_d  = mem_addr_q;
    mem_dat_w_d = mem_dat_w_q;
    mem_we_d    = mem_we_q;
    ack_d       = 1'b0;
    mem_stb_d   = 1'b0;
    case (state_q)
      IDLE: if (i_stb) begin
        off_d       = in_off;
        we_d        = i_we;
        dat_d       = i_dat_w;
        mem_addr_d  = {i_addr[31:2], 2'b00};
        mem_we_d    = st_mem_we;
        mem_dat_w_d = st_mem_dat_w;
        mem_stb_d   = 1'b1;
        state_d     = WAIT1;
      end
      WAIT1: if (i_mem_ack) begin
        if (need2) begin
          lo_d        = i_mem_dat_r;
          mem_addr_d  = mem_addr_q + 32'd4;
          mem_we_d    = st_mem_we;
          mem_dat_w_d = st_mem_dat_w;
          mem_stb_d   = 1'b1;
          state_d     = WAIT2;
        end else begin
          dat_r_d = i_mem_dat_r;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT2: if (i_mem_ack) begin
        dat_r_d = joined;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      dat_q       <= '0;
      lo_q        <= '0;
      we_q        <= '0;
      off_q       <= '0;
      dat_r_q     <= '0;
      mem_addr_q  <= '0;
      mem_dat_w_q <= '0;
      mem_we_q    <= '0;
      ack_q       <= 1'b0;
      mem_stb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dat_q       <= dat_d;
      lo_q        <= lo_d;
      we_q        <= we_d;
      off_q       <= off_d;
      dat_r_q     <= dat_r_d;
      mem_addr_q  <= mem_addr_d;
      mem_dat_w_q <= mem_dat_w_d;
      mem_we_q    <= mem_we_d;
      ack_q       <= ack_d;
      mem_stb_q   <= mem_stb_d;
    end
  end

  assign o_dat_r     = dat_r_q;
  assign o_ack       = ack_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_dat_w = mem_dat_w_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_stb   = mem_stb_q;
endmodule

// File: tb/tb_or32_bus_align.sv
// tb_or32_bus_align: directed vector table, reset-in-flight sequence and random traffic
// checked against a byte-addressed memory model of the core's view.
module tb_or32_bus_align;
  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic [31:0] i_addr = '0, i_dat_w = '0, i_mem_dat_r = '0;
  logic [3:0]  i_we = '0;
  logic        i_stb = 1'b0, i_mem_ack = 1'b0;
  logic [31:0] o_dat_r, o_mem_addr, o_mem_dat_w;
  logic [3:0]  o_mem_we;
  logic        o_ack, o_mem_stb;

  or32_bus_align #(.SPLIT_UNALIGNED(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_dat_w(i_dat_w), .i_we(i_we),
    .i_stb(i_stb), .o_dat_r(o_dat_r), .o_ack(o_ack), .o_mem_addr(o_mem_addr),
    .o_mem_dat_w(o_mem_dat_w), .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb),
    .i_mem_dat_r(i_mem_dat_r), .i_mem_ack(i_mem_ack)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr, dat;
    logic [3:0]  we;
    int          lat, n;
    logic [31:0] a0; logic [3:0] m0; logic [31:0] d0;
    logic [31:0] a1; logic [3:0] m1; logic [31:0] d1;
    logic [31:0] rd;
  } vec_t;
  typedef struct { logic [31:0] a; logic [3:0] we; logic [31:0] d; } acc_t;

  int applied = 0, miscomp = 0;
  logic [31:0] cur_addr;
  logic [7:0] mem_b [logic [31:0]];
  logic [7:0] ref_b [logic [31:0]];
  acc_t log_q[$];
  int mem_lat = 0;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] rdm(input logic [31:0] a);
    return mem_b.exists(a) ? mem_b[a] : dflt(a);
  endfunction
  function automatic logic [7:0] rdr(input logic [31:0] a);
    return ref_b.exists(a) ? ref_b[a] : dflt(a);
  endfunction
  function automatic logic [31:0] bm(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // word memory with a programmable ack delay; ack may land in the strobe cycle
  logic        pend = 1'b0;
  logic [31:0] pa, pd;
  logic [3:0]  pwe;
  int          cnt;
  always @(negedge i_clk) begin
    i_mem_ack   = 1'b0;
    i_mem_dat_r = $urandom;
    if (o_mem_stb) begin
      pend = 1'b1; pa = o_mem_addr; pwe = o_mem_we; pd = o_mem_dat_w; cnt = mem_lat;
      log_q.push_back('{pa, pwe, pd});
    end
    if (pend) begin
      if (cnt == 0) begin
        for (int j = 0; j < 4; j++) if (pwe[j]) mem_b[pa + 32'(j)] = pd[8*j +: 8];
        i_mem_dat_r = {rdm(pa + 32'd3), rdm(pa + 32'd2), rdm(pa + 32'd1), rdm(pa)};
        i_mem_ack   = 1'b1;
        pend        = 1'b0;
      end else cnt--;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s (core addr %h): got %h expected %h", nm, cur_addr, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, {31'b0, o_ack}, 32'h0);
    chk({tag, "_mem_stb"}, {31'b0, o_mem_stb}, 32'h0);
    chk({tag, "_mem_we"}, {28'b0, o_mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, o_mem_addr, 32'h0);
    chk({tag, "_mem_dat_w"}, o_mem_dat_w, 32'h0);
    chk({tag, "_dat_r"}, o_dat_r, 32'h0);
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    for (int j = 0; j < 4; j++) begin
      mem_b[a + 32'(j)] = w[8*j +: 8];
      ref_b[a + 32'(j)] = w[8*j +: 8];
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, dat, input logic [3:0] we, input int lat, n,
                              input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] d1,
                              input logic [31:0] rd);
    vec_t v;
    v.addr = addr; v.dat = dat; v.we = we; v.lat = lat; v.n = n;
    v.a0 = a0; v.m0 = m0; v.d0 = d0; v.a1 = a1; v.m1 = m1; v.d1 = d1; v.rd = rd;
    return v;
  endfunction

  // core-level model: walk the touched bytes and sort them into the words they live in
  function automatic vec_t build(input logic [31:0] addr, dat, input logic [3:0] we, input int lat);
    vec_t v;
    logic [31:0] b;
    int nb;
    v = mk(addr, dat, we, lat, 1, {addr[31:2], 2'b00}, 4'h0, 32'h0,
           {addr[31:2], 2'b00} + 32'd4, 4'h0, 32'h0, 32'h0);
    nb = (we == 4'h1) ? 1 : 4;
    for (int i = 0; i < nb; i++) begin
      b = addr + 32'(i);
      if (b[31:2] != addr[31:2]) begin
        v.n = 2;
        if (we != 4'h0) begin v.m1[b[1:0]] = 1'b1; v.d1[8*b[1:0] +: 8] = dat[8*i +: 8]; end
      end else if (we != 4'h0) begin
        v.m0[b[1:0]] = 1'b1; v.d0[8*b[1:0] +: 8] = dat[8*i +: 8];
      end
    end
    for (int i = 0; i < 4; i++) v.rd[8*i +: 8] = rdr(addr + 32'(i));
    return v;
  endfunction

  task automatic ref_update(input vec_t v);
    if (v.we != 4'h0)
      for (int i = 0; i < ((v.we == 4'h1) ? 1 : 4); i++) ref_b[v.addr + 32'(i)] = v.dat[8*i +: 8];
  endtask

  task automatic run_vec(input vec_t v);
    int base, got_lat, n_got;
    logic ack2;
    logic [31:0] rd;
    cur_addr = v.addr;
    mem_lat  = v.lat;
    base     = log_q.size();
    got_lat  = -1;
    rd       = 32'h0;
    @(posedge i_clk); #1;
    i_addr = v.addr; i_dat_w = v.dat; i_we = v.we; i_stb = 1'b1;
    @(posedge i_clk); #1;
    i_stb = 1'b0; i_addr = $urandom; i_dat_w = $urandom; i_we = 4'(v.we + 4'h3);
    for (int k = 1; k <= 100; k++) begin
      @(negedge i_clk);
      if (o_ack) begin got_lat = k; rd = o_dat_r; break; end
    end
    @(negedge i_clk);
    ack2  = o_ack;
    n_got = log_q.size() - base;
    chk("latency", 32'(got_lat), 32'(v.n == 2 ? 3 + 2 * v.lat : 2 + v.lat));
    chk("ack_pulse", {31'b0, ack2}, 32'h0);
    chk("n_access", 32'(n_got), 32'(v.n));
    if (n_got >= 1) begin
      chk("addr0", log_q[base].a, v.a0);
      chk("we0", {28'b0, log_q[base].we}, {28'b0, v.m0});
      if (v.m0 != 4'h0) chk("dat0", log_q[base].d & bm(v.m0), v.d0 & bm(v.m0));
    end
    if (n_got >= 2 && v.n == 2) begin
      chk("addr1", log_q[base + 1].a, v.a1);
      chk("we1", {28'b0, log_q[base + 1].we}, {28'b0, v.m1});
      if (v.m1 != 4'h0) chk("dat1", log_q[base + 1].d & bm(v.m1), v.d1 & bm(v.m1));
    end
    if (v.we == 4'h0) chk("rdata", rd, v.rd);
  endtask

  vec_t tbl[10];

  initial begin
    int seen, acks;
    tbl[0] = mk(32'h101, 32'h0, 4'h0, 0, 2, 32'h100, 4'h0, 32'h0, 32'h104, 4'h0, 32'h0, 32'h55443322);
    tbl[1] = mk(32'h100, 32'h0, 4'h0, 0, 1, 32'h100, 4'h0, 32'h0, 32'h104, 4'h0, 32'h0, 32'h44332211);
    tbl[2] = mk(32'h100, 32'hAABBCCDD, 4'hF, 0, 1, 32'h100, 4'hF, 32'hAABBCCDD, 32'h104, 4'h0, 32'h0, 32'h0);
    tbl[3] = mk(32'h203, 32'h0000005A, 4'h1, 2, 1, 32'h200, 4'h8, 32'h5A5A5A5A, 32'h204, 4'h0, 32'h0, 32'h0);
    tbl[4] = mk(32'h102, 32'hAABBCCDD, 4'hF, 1, 2, 32'h100, 4'hC, 32'hCCDD0000, 32'h104, 4'h3, 32'h0000AABB, 32'h0);
    tbl[5] = mk(32'h100, 32'h0, 4'h0, 0, 1, 32'h100, 4'h0, 32'h0, 32'h104, 4'h0, 32'h0, 32'hCCDDCCDD);
    tbl[6] = mk(32'h103, 32'h0, 4'h0, 2, 2, 32'h100, 4'h0, 32'h0, 32'h104, 4'h0, 32'h0, 32'h77AABBCC);
    tbl[7] = mk(32'hFFFFFFFE, 32'h0, 4'h0, 3, 2, 32'hFFFFFFFC, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'hC0D01122);
    tbl[8] = mk(32'h101, 32'hFFFFFF77, 4'h1, 1, 1, 32'h100, 4'h2, 32'h77777777, 32'h104, 4'h0, 32'h0, 32'h0);
    tbl[9] = mk(32'h101, 32'h0, 4'h0, 0, 2, 32'h100, 4'h0, 32'h0, 32'h104, 4'h0, 32'h0, 32'hBBCCDD77);
    cur_addr = 32'h0;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_rst_n = 1'b1;
    poke(32'h100, 32'h44332211);
    poke(32'h104, 32'h88776655);
    poke(32'hFFFFFFFC, 32'h11223344);
    poke(32'h0, 32'hA0B0C0D0);
    foreach (tbl[i]) begin
      run_vec(tbl[i]);
      ref_update(tbl[i]);
    end
    // reset while the second half of a split load is outstanding
    cur_addr = 32'h101;
    mem_lat  = 5;
    seen     = log_q.size();
    @(posedge i_clk); #1;
    i_addr = 32'h101; i_we = 4'h0; i_stb = 1'b1;
    @(posedge i_clk); #1;
    i_stb = 1'b0;
    acks  = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge i_clk);
      if (o_ack) acks++;
      if (log_q.size() - seen >= 2) break;
    end
    chk("reach_wait2", 32'(log_q.size() - seen), 32'd2);
    #2 i_rst_n = 1'b0;
    #1 chk_zero("rst_wait2");
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      if (o_ack) acks++;
    end
    chk("no_ack_dropped", 32'(acks), 32'd0);
    run_vec(build(32'h200, 32'h0, 4'h0, 0));
    for (int t = 0; t < 250; t++) begin
      vec_t v;
      logic [31:0] a;
      logic [3:0] we;
      a  = $urandom_range(0, 1) ? 32'h300 + 32'($urandom_range(0, 63))
                                : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: we = 4'h0;
        1: we = 4'h1;
        default: we = 4'hF;
      endcase
      v = build(a, $urandom, we, int'($urandom_range(0, 2)));
      run_vec(v);
      ref_update(v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscomp);
    $finish;
  end
endmodule
